// File: rtl/fft_reorder_ctrl_pkg.sv
// fft_reorder_ctrl_pkg: frame geometry, sequencer state encoding and bit-reversal helper
package fft_reorder_ctrl_pkg;
  localparam int LOGN = 6;
  localparam int FRAME = 1 << LOGN;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;
  function automatic logic [LOGN-1:0] bitrev6(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_addr_gen.sv
// reorder_addr_gen: sample counter, pattern parity and natural/bit-reversed RAM address mux
module reorder_addr_gen
  import fft_reorder_ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            inc,
  input  logic            clr,
  input  logic            idle,
  output logic [LOGN-1:0] cnt,
  output logic [LOGN-1:0] addr
);
  logic            par;
  logic [LOGN-1:0] idx;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt <= '0;
      par <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      par <= 1'b0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
      par <= par ^ (&cnt);
    end
  // each frame alternates the pattern so the read of the old frame and the write of the new share one address
  always_comb begin
    idx  = idle ? '0 : cnt;
    addr = par ? bitrev6(idx) : idx;
  end
endmodule

// File: rtl/fft_reorder_ctrl.sv
// fft_reorder_ctrl: RAM64 sequencer for streaming bit-reversed/natural reorder.
// Define FFT_REORDER_ERR_EN to add the sticky ERR output for misplaced START.
module fft_reorder_ctrl
  import fft_reorder_ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ED,
  input  logic            START,
  output logic            RAM_ED,
  output logic            RAM_WE,
  output logic [LOGN-1:0] RAM_ADDR,
  output logic            OUT_VALID,
  output logic            OUT_START
`ifdef FFT_REORDER_ERR_EN
  ,output logic           ERR
`endif
);
  state_t          state, state_nx;
  logic [LOGN-1:0] cnt;
  logic            bnd, inc, clr, vld_nx;
  reorder_addr_gen u_addr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .inc  (inc),
    .clr  (clr),
    .idle (state == IDLE),
    .cnt  (cnt),
    .addr (RAM_ADDR)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else if (ED) state <= state_nx;
  // the frame-boundary access in FILL already returns sample 0 of the previous frame
  always_comb begin
    bnd      = cnt == '0;
    state_nx = state == IDLE  ? (START ? FILL : IDLE) :
               state == DRAIN ? (&cnt ? IDLE : DRAIN) :
               bnd            ? (START ? STREAM : DRAIN) : state;
    inc      = ED & (state != IDLE | START);
    clr      = ED & state == DRAIN & (&cnt);
    RAM_ED   = ED;
    RAM_WE   = RST_N & ED & (state == IDLE ? START : state != DRAIN & (!bnd | START));
    vld_nx   = state == STREAM | state == DRAIN | (state == FILL & bnd);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_START <= 1'b0;
    end else if (ED) begin
      OUT_VALID <= vld_nx;
      OUT_START <= vld_nx & bnd;
    end
`ifdef FFT_REORDER_ERR_EN
  logic bad;
  always_comb bad = START & (state == DRAIN | (state != IDLE & !bnd));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) ERR <= 1'b0;
    else if (ED & bad) ERR <= 1'b1;
`endif
endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// tb_fft_reorder_ctrl: randomized frames through a read-old-data RAM64 model, checked against a frame-level reorder model
module tb_fft_reorder_ctrl;
  logic        CLK = 0, RST_N = 0, ED = 0, START = 0;
  logic        RAM_ED, RAM_WE, OUT_VALID, OUT_START;
  logic [5:0]  RAM_ADDR;
  logic [15:0] DI = 0, DO;
  logic [15:0] mem [64];
`ifdef FFT_REORDER_ERR_EN
  logic        ERR;
`endif
  int          checks = 0, failures = 0;
  int          ec = 1, last = 0, s_last = -1000, fp = 0;
  bit          err_exp = 0;
  bit          exp_v [4096];
  bit          exp_s [4096];
  logic [15:0] exp_d [4096];
  logic [15:0] fr [64];

  fft_reorder_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .ED(ED), .START(START),
    .RAM_ED(RAM_ED), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .OUT_VALID(OUT_VALID), .OUT_START(OUT_START)
`ifdef FFT_REORDER_ERR_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (RAM_ED) begin
    DO <= mem[RAM_ADDR];
    if (RAM_WE) mem[RAM_ADDR] <= DI;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    repeat (6) begin r = r * 2 + x % 2; x = x / 2; end
    return r;
  endfunction

  function automatic int exp_addr();
    int p = ec - s_last;
    if (p >= 0 && p < 64) return fp ? rev(p) : p;
    if (p >= 64 && p < 128) return fp ? p - 64 : rev(p - 64);
    return 0;
  endfunction

  task automatic cycle(input bit en, input bit st);
    int p;
    @(negedge CLK);
    ED = en; START = st; DI = 16'($urandom);
    if (en && st) begin
      if (ec == s_last + 64 || ec >= s_last + 128) begin
        fp = (ec == s_last + 64) ? 1 - fp : 0;
        s_last = ec;
        for (int k = 0; k < 64; k++) fr[k] = 16'($urandom);
        for (int k = 0; k < 64; k++) begin
          exp_v[ec+64+k] = 1;
          exp_s[ec+64+k] = (k == 0);
          exp_d[ec+64+k] = fr[rev(k)];
        end
      end else err_exp = 1;
    end
    p = ec - s_last;
    if (p >= 0 && p < 64) DI = fr[p];
    #1;
    chk("ram_we", RAM_WE, en && p >= 0 && p < 64);
    chk("ram_addr", RAM_ADDR, exp_addr());
    chk("ram_ed", RAM_ED, en);
    @(posedge CLK); #1;
    if (en) begin last = ec; ec++; end
    chk("out_valid", OUT_VALID, exp_v[last]);
    chk("out_start", OUT_START, exp_s[last]);
    if (exp_v[last]) chk("do", DO, exp_d[last]);
`ifdef FFT_REORDER_ERR_EN
    chk("err", ERR, err_exp);
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RST_N = 0; ED = 1; START = 1;
    #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_start", OUT_START, 0);
    chk("rst_we", RAM_WE, 0);
    chk("rst_addr", RAM_ADDR, 0);
`ifdef FFT_REORDER_ERR_EN
    chk("rst_err", ERR, 0);
`endif
    s_last = -1000; fp = 0; err_exp = 0; last = 0;
    for (int i = ec; i < ec + 200; i++) begin exp_v[i] = 0; exp_s[i] = 0; end
    @(posedge CLK); @(negedge CLK);
    RST_N = 1; START = 0;
  endtask

  task automatic gap(input int mode);
    if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) cycle(0, 1'($urandom));
  endtask

  task automatic frames(input int n, input int mode, input int bad);
    for (int f = 0; f < n; f++)
      for (int k = 0; k < 64; k++) begin gap(mode); cycle(1, k == 0 || k == bad); end
    for (int k = 0; k < 64; k++) begin gap(mode); cycle(1, k == bad); end
  endtask

  initial begin
    do_reset();
    frames(3, 0, -1);
    frames(2, 1, -1);
    frames(2, 2, 17);
    for (int k = 0; k < 64; k++) cycle(1, k == 0);
    for (int k = 0; k < 40; k++) cycle(1, k == 0);
    do_reset();
    frames(1, 2, -1);
    repeat (3) cycle(1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
